// File: rtl/afe_pkg.sv
// rtl/afe_pkg.sv - shared constants, state type and word-order helper for the AFE RX front end
package afe_pkg;

  localparam int AFE_WORD_W      = 12;
  localparam int AFE_N_WORDS     = 2;
  // Widest frame the word-reversal helper can handle.
  localparam int AFE_FRAME_MAX_W = 256;
  localparam int AFE_BIT_IDX_W   = $clog2(AFE_FRAME_MAX_W);

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } afe_state_e;

  // Reverse the order of n_words words of word_w bits held in the low bits
  // of frame; bits above n_words*word_w come back as zero.
  function automatic logic [AFE_FRAME_MAX_W-1:0] afe_reverse_words(
    input logic [AFE_FRAME_MAX_W-1:0] frame,
    input int                         n_words,
    input int                         word_w
  );
    logic [AFE_FRAME_MAX_W-1:0] rev;
    int                         src_word;
    int                         dst_bit;
    rev = '0;
    for (int b = 0; b < AFE_FRAME_MAX_W; b++) begin
      if (b < n_words * word_w) begin
        src_word = b / word_w;
        dst_bit  = (n_words - 1 - src_word) * word_w + (b % word_w);
        rev[AFE_BIT_IDX_W'(dst_bit)] = frame[AFE_BIT_IDX_W'(b)];
      end
    end
    return rev;
  endfunction

endpackage

// File: rtl/afe_sat_counter.sv
// rtl/afe_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {CNT_W{1'b1}})) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/afe_rx_deint.sv
// rtl/afe_rx_deint.sv - AFE word-serial RX framer, deinterleaver and decimator feeding the RX FIFO
module afe_rx_deint
  import afe_pkg::*;
#(
  parameter int WORD_W  = AFE_WORD_W,
  parameter int N_WORDS = AFE_N_WORDS,
  parameter int CNT_W   = 16,
  parameter int DEC_W   = 8
) (
  input  logic                      sclk_2x,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      sel,
  input  logic [WORD_W-1:0]         d,
  input  logic                      swap,
  input  logic [DEC_W-1:0]          decim,
  input  logic                      fifo_full,
  output logic [WORD_W*N_WORDS-1:0] fifo_data,
  output logic                      fifo_wr,
  output logic [CNT_W-1:0]          drop_cnt,
  output logic [CNT_W-1:0]          ferr_cnt,
  input  logic                      clr_cnt,
  output logic                      locked
);

  localparam int FRAME_W = WORD_W * N_WORDS;
  localparam int IDX_W   = $clog2(N_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  afe_state_e               state;
  logic [IDX_W-1:0]         idx;
  logic [DEC_W-1:0]         dec_cnt;
  // Words 0..N-2 of the frame in progress; the last word is taken straight from d.
  logic [FRAME_W-WORD_W-1:0] wbuf;
  logic [FRAME_W-1:0]       cur_frame;

  logic collecting;
  logic frame_done;
  logic eligible;
  logic ferr_inc;
  logic drop_inc;

  assign cur_frame  = {d, wbuf};
  assign collecting = enable && (state == COLLECT);
  assign frame_done = collecting && !sel && (idx == LAST_IDX);
  assign eligible   = (dec_cnt == '0);
  // Early sel (mid-frame) or missing sel (frame start) are both framing errors.
  assign ferr_inc   = collecting && ((sel && (idx != '0)) || (!sel && (idx == '0)));
  assign drop_inc   = frame_done && eligible && fifo_full;
  assign locked     = (state == COLLECT);

  // Framing FSM, word capture, decimation and the registered FIFO write port.
  always_ff @(posedge sclk_2x) begin
    if (!reset_n) begin
      state     <= HUNT;
      idx       <= '0;
      dec_cnt   <= '0;
      wbuf      <= '0;
      fifo_data <= '0;
      fifo_wr   <= 1'b0;
    end else begin
      fifo_wr <= 1'b0;
      if (!enable) begin
        state <= HUNT;
        idx   <= '0;
      end else begin
        case (state)
          HUNT: begin
            if (sel) begin
              wbuf[WORD_W-1:0] <= d;
              idx              <= IDX_W'(1);
              state            <= COLLECT;
            end
          end
          COLLECT: begin
            if (sel) begin
              // Expected or early start: this word always begins a new frame.
              wbuf[WORD_W-1:0] <= d;
              idx              <= IDX_W'(1);
            end else if (idx == '0) begin
              state <= HUNT;
            end else if (idx == LAST_IDX) begin
              idx <= '0;
              if (eligible) begin
                dec_cnt <= decim;
                if (!fifo_full) begin
                  fifo_wr <= 1'b1;
                  if (swap) begin
                    fifo_data <= FRAME_W'(afe_reverse_words(AFE_FRAME_MAX_W'(cur_frame),
                                                            N_WORDS, WORD_W));
                  end else begin
                    fifo_data <= cur_frame;
                  end
                end
              end else begin
                dec_cnt <= dec_cnt - DEC_W'(1);
              end
            end else begin
              for (int i = 1; i < N_WORDS - 1; i++) begin
                if (idx == IDX_W'(i)) begin
                  wbuf[i*WORD_W +: WORD_W] <= d;
                end
              end
              idx <= idx + IDX_W'(1);
            end
          end
          default: begin
            state <= HUNT;
            idx   <= '0;
          end
        endcase
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk     (sclk_2x),
    .reset_n (reset_n),
    .inc     (drop_inc),
    .clr     (clr_cnt),
    .q       (drop_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_ferr_cnt (
    .clk     (sclk_2x),
    .reset_n (reset_n),
    .inc     (ferr_inc),
    .clr     (clr_cnt),
    .q       (ferr_cnt)
  );

endmodule

// File: tb/tb_afe_rx_deint.sv
// tb/tb_afe_rx_deint.sv - directed self-checking bench for afe_rx_deint (2-word and 4-word frames)
module tb_afe_rx_deint;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        sel;
  logic [11:0] d;
  logic        swap;
  logic [7:0]  decim;
  logic        fifo_full;
  logic        clr_cnt;

  logic [23:0] fifo_data2;
  logic        fifo_wr2;
  logic [3:0]  drop_cnt2;
  logic [3:0]  ferr_cnt2;
  logic        locked2;

  logic [47:0] fifo_data4;
  logic        fifo_wr4;
  logic [15:0] drop_cnt4;
  logic [15:0] ferr_cnt4;
  logic        locked4;

  int passed = 0;
  int total  = 0;
  int wr_count;
  logic [12:0] wr_mask;

  always #5 clk = ~clk;

  afe_rx_deint #(.WORD_W(12), .N_WORDS(2), .CNT_W(4), .DEC_W(8)) u_dut2 (
    .sclk_2x   (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .sel       (sel),
    .d         (d),
    .swap      (swap),
    .decim     (decim),
    .fifo_full (fifo_full),
    .fifo_data (fifo_data2),
    .fifo_wr   (fifo_wr2),
    .drop_cnt  (drop_cnt2),
    .ferr_cnt  (ferr_cnt2),
    .clr_cnt   (clr_cnt),
    .locked    (locked2)
  );

  afe_rx_deint #(.WORD_W(12), .N_WORDS(4), .CNT_W(16), .DEC_W(8)) u_dut4 (
    .sclk_2x   (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .sel       (sel),
    .d         (d),
    .swap      (swap),
    .decim     (decim),
    .fifo_full (fifo_full),
    .fifo_data (fifo_data4),
    .fifo_wr   (fifo_wr4),
    .drop_cnt  (drop_cnt4),
    .ferr_cnt  (ferr_cnt4),
    .clr_cnt   (clr_cnt),
    .locked    (locked4)
  );

  // Present one word at a negedge; returns at the next negedge, after the
  // rising edge that sampled it, so outputs reflect that edge.
  task automatic cyc(input logic s, input logic [11:0] dv);
    sel = s;
    d   = dv;
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b1;
    sel       = 1'b0;
    d         = '0;
    swap      = 1'b0;
    decim     = 8'd0;
    fifo_full = 1'b0;
    clr_cnt   = 1'b0;
    @(negedge clk);
    cyc(1'b1, 12'hFFF);
    check("rst_data", 64'(fifo_data2), 64'h0);
    check("rst_wr", 64'(fifo_wr2), 64'h0);
    check("rst_drop", 64'(drop_cnt2), 64'h0);
    check("rst_ferr", 64'(ferr_cnt2), 64'h0);
    check("rst_locked", 64'(locked2), 64'h0);
    reset_n = 1'b1;

    // Basic 2-word frame, 1-cycle latency.
    cyc(1'b1, 12'h123);
    check("basic_locked", 64'(locked2), 64'h1);
    check("basic_wr_early", 64'(fifo_wr2), 64'h0);
    cyc(1'b0, 12'h456);
    check("basic_wr", 64'(fifo_wr2), 64'h1);
    check("basic_data", 64'(fifo_data2), 64'h456123);
    cyc(1'b1, 12'hABC);
    check("b2b_wr_gap", 64'(fifo_wr2), 64'h0);
    cyc(1'b0, 12'hDEF);
    check("b2b_data", 64'(fifo_data2), 64'hDEFABC);
    wr_count = 0;
    for (int f = 0; f < 6; f++) begin
      cyc(1'b1, 12'(f));
      wr_count += int'(fifo_wr2);
      cyc(1'b0, 12'(f + 16));
      wr_count += int'(fifo_wr2);
    end
    check("b2b_wr_count", 64'(wr_count), 64'd6);

    // Early sel on the second word.
    cyc(1'b1, 12'h111);
    cyc(1'b1, 12'h222);
    check("early_ferr", 64'(ferr_cnt2), 64'd1);
    check("early_wr", 64'(fifo_wr2), 64'h0);
    check("early_locked", 64'(locked2), 64'h1);
    cyc(1'b0, 12'h333);
    check("early_restart", 64'(fifo_data2), 64'h333222);

    // Missing sel at frame start.
    cyc(1'b0, 12'h444);
    check("miss_ferr", 64'(ferr_cnt2), 64'd2);
    check("miss_locked", 64'(locked2), 64'h0);
    cyc(1'b0, 12'h555);
    check("hunt_locked", 64'(locked2), 64'h0);
    check("hunt_ferr", 64'(ferr_cnt2), 64'd2);
    cyc(1'b1, 12'h666);
    check("relock", 64'(locked2), 64'h1);
    cyc(1'b0, 12'h777);
    check("relock_data", 64'(fifo_data2), 64'h777666);

    // FIFO full across 3 frames.
    fifo_full = 1'b1;
    wr_count  = 0;
    for (int f = 0; f < 3; f++) begin
      cyc(1'b1, 12'h0A0 + 12'(f));
      wr_count += int'(fifo_wr2);
      cyc(1'b0, 12'h0B0 + 12'(f));
      wr_count += int'(fifo_wr2);
    end
    check("full_no_wr", 64'(wr_count), 64'd0);
    check("full_drop", 64'(drop_cnt2), 64'd3);
    check("full_data_hold", 64'(fifo_data2), 64'h777666);
    cyc(1'b1, 12'h0C0);
    clr_cnt = 1'b1;
    cyc(1'b0, 12'h0C1);
    clr_cnt = 1'b0;
    check("clr_vs_drop", 64'(drop_cnt2), 64'd0);
    check("clr_ferr", 64'(ferr_cnt2), 64'd0);
    fifo_full = 1'b0;

    // Decimation by 3: frames 1, 4, 7 are written.
    decim   = 8'd2;
    wr_mask = '0;
    for (int f = 0; f < 9; f++) begin
      cyc(1'b1, 12'h200 + 12'(f));
      cyc(1'b0, 12'h300 + 12'(f));
      wr_mask[f] = fifo_wr2;
    end
    check("decim_mask", 64'(wr_mask), 64'h049);
    check("decim_last_data", 64'(fifo_data2), 64'h306206);
    cyc(1'b1, 12'h210);
    cyc(1'b0, 12'h310);
    check("decim_f10_wr", 64'(fifo_wr2), 64'h1);
    fifo_full = 1'b1;
    cyc(1'b1, 12'h211);
    cyc(1'b0, 12'h311);
    check("skip_full_wr", 64'(fifo_wr2), 64'h0);
    check("skip_full_drop", 64'(drop_cnt2), 64'd0);
    fifo_full = 1'b0;
    decim     = 8'd0;
    cyc(1'b1, 12'h212);
    cyc(1'b0, 12'h312);
    check("decim_reload_skip", 64'(fifo_wr2), 64'h0);
    cyc(1'b1, 12'h213);
    cyc(1'b0, 12'h313);
    check("decim_reload_wr", 64'(fifo_wr2), 64'h1);
    check("decim_reload_data", 64'(fifo_data2), 64'h313213);

    // Saturate ferr with a run of early sels; restart stays normal.
    cyc(1'b1, 12'h010);
    for (int i = 0; i < 20; i++) cyc(1'b1, 12'h020 + 12'(i));
    check("sat_ferr", 64'(ferr_cnt2), 64'hF);
    check("sat_locked", 64'(locked2), 64'h1);
    cyc(1'b0, 12'h0FF);
    check("sat_restart_wr", 64'(fifo_wr2), 64'h1);
    check("sat_restart_data", 64'(fifo_data2), 64'h0FF033);
    check("sat_hold", 64'(ferr_cnt2), 64'hF);
    clr_cnt = 1'b1;
    cyc(1'b1, 12'h100);
    cyc(1'b1, 12'h101);
    clr_cnt = 1'b0;
    check("clr_vs_ferr", 64'(ferr_cnt2), 64'd0);

    // 4-word frames, with and without swap.
    reset_n = 1'b0;
    cyc(1'b0, 12'h000);
    reset_n = 1'b1;
    check("rst4_locked", 64'(locked4), 64'h0);
    check("rst4_data", 64'(fifo_data4), 64'h0);
    swap = 1'b1;
    cyc(1'b1, 12'h001);
    cyc(1'b0, 12'h002);
    cyc(1'b0, 12'h003);
    check("w4_wr_early", 64'(fifo_wr4), 64'h0);
    cyc(1'b0, 12'h004);
    check("w4_swap_wr", 64'(fifo_wr4), 64'h1);
    check("w4_swap_data", 64'(fifo_data4), 64'h001002003004);
    swap = 1'b0;
    cyc(1'b1, 12'h001);
    cyc(1'b0, 12'h002);
    cyc(1'b0, 12'h003);
    cyc(1'b0, 12'h004);
    check("w4_noswap_data", 64'(fifo_data4), 64'h004003002001);
    check("w4_ferr", 64'(ferr_cnt4), 64'd0);
    check("w2_ferr_pre_rst", 64'(ferr_cnt2), 64'd2);

    // Reset in the middle of a 2-word frame.
    cyc(1'b1, 12'hAAA);
    reset_n = 1'b0;
    cyc(1'b0, 12'hBBB);
    reset_n = 1'b1;
    check("midrst_data", 64'(fifo_data2), 64'h0);
    check("midrst_wr", 64'(fifo_wr2), 64'h0);
    check("midrst_ferr", 64'(ferr_cnt2), 64'h0);
    check("midrst_locked", 64'(locked2), 64'h0);
    cyc(1'b0, 12'hCCC);
    check("midrst_hunt_wr", 64'(fifo_wr2), 64'h0);
    check("midrst_hunt_ferr", 64'(ferr_cnt2), 64'h0);

    // Enable dropped in the middle of a frame.
    cyc(1'b1, 12'h101);
    enable = 1'b0;
    cyc(1'b0, 12'h202);
    check("en_off_wr", 64'(fifo_wr2), 64'h0);
    check("en_off_locked", 64'(locked2), 64'h0);
    enable = 1'b1;
    cyc(1'b0, 12'h303);
    check("en_on_locked", 64'(locked2), 64'h0);
    check("en_on_ferr", 64'(ferr_cnt2), 64'h0);
    check("en_on_wr", 64'(fifo_wr2), 64'h0);
    cyc(1'b1, 12'h404);
    cyc(1'b0, 12'h505);
    check("en_resume_data", 64'(fifo_data2), 64'h505404);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/afe_rx_deint.md
Name: afe_rx_deint

Overview:
- Parametrised successor AFE RX front end.
- Samples a word-serial AFE bus framed by `sel`, assembles `N_WORDS` words into one frame, optionally swaps word order and decimates, then writes frames into the RX FIFO.
- Counts dropped frames (FIFO full) and framing errors.
- Sits between the AFE pins and the RX FIFO, clocked by the AFE sample clock.

Parameters:
- `WORD_W`, 12, width of one AFE bus word (one I or Q sample).
- `N_WORDS`, 2, words per frame (2 = I/Q pair, 4 = two-channel I/Q); must be >= 2.
- `CNT_W`, 16, width of the drop and framing-error counters.
- `DEC_W`, 8, width of the decimation ratio input.

Ports:
- `sclk_2x`  in  1  AFE word clock; sole clock; all logic on its rising edge.
- `reset_n`  in  1  synchronous active-low reset.
- `enable`  in  1  capture enable; low forces HUNT and suppresses writes.
- `sel`  in  1  frame marker; high on the first word of a frame.
- `d`  in  `WORD_W`  AFE data word.
- `swap`  in  1  0: `fifo_data = {w[N-1]..w[0]}`; 1: word order reversed.
- `decim`  in  `DEC_W`  write one frame in every `decim+1` complete frames.
- `fifo_full`  in  1  RX FIFO full.
- `fifo_data`  out  `WORD_W*N_WORDS`  assembled frame, registered.
- `fifo_wr`  out  1  one-cycle write strobe.
- `drop_cnt`  out  `CNT_W`  frames lost to `fifo_full`; saturating.
- `ferr_cnt`  out  `CNT_W`  framing errors; saturating.
- `clr_cnt`  in  1  synchronous clear of both counters.
- `locked`  out  1  high while in COLLECT.

Behaviour:
- Reset (`reset_n` low at an edge): state HUNT, word index 0, decimation counter 0. Outputs `fifo_data`=0, `fifo_wr`=0, `drop_cnt`=0, `ferr_cnt`=0, `locked`=0. Reset mid-frame discards the partial frame.
- HUNT:
  - `d` is ignored until `sel`=1 with `enable`=1.
  - That word is stored as `w[0]`, index becomes 1, state goes to COLLECT.
- COLLECT:
  - Each cycle with `sel`=0: `w[index] <= d`, index increments.
  - When index == `N_WORDS-1` is written, the frame is complete and index returns to 0. The state stays COLLECT expecting `sel`=1 next cycle.
- Expected frame start:
  - At index 0, `sel`=1 starts the next frame.
  - At index 0, `sel`=0 is a framing error: `ferr_cnt`++, state goes to HUNT, the word is discarded.
- Early `sel`:
  - `sel`=1 at index != 0 is a framing error: `ferr_cnt`++, the partial frame is discarded.
  - That word is taken as the new `w[0]` and index becomes 1; the state stays COLLECT.
- Frame complete:
  - If the decimation counter == 0, the frame is eligible, then the counter reloads to `decim`; otherwise the counter decrements and the frame is silently skipped (not a drop).
  - Eligible and `fifo_full`=0: the cycle after the last word, `fifo_data` is updated (with `swap` applied, sampled on the completing cycle) and `fifo_wr`=1 for exactly one cycle.
  - Eligible and `fifo_full`=1: no write, `fifo_data` holds, `drop_cnt`++.
  - Latency from the last word sampled to `fifo_wr`: 1 cycle.
- `decim`=0 writes every frame. A change to `decim` takes effect at the next reload.
- `enable` low:
  - State goes to HUNT next cycle; the partial frame is discarded; `fifo_wr`=0.
  - Counters hold; no error is counted.
- Counters:
  - Saturate at all-ones.
  - `clr_cnt` has priority over a same-cycle increment (result 0).
- Simultaneous events: an early `sel` on the cycle a counter saturates leaves the counter saturated; frame restart proceeds as normal.
- `fifo_full` is sampled on the frame-complete cycle only.

Decomposition:
- Shared package `afe_pkg`:
  - `AFE_WORD_W`=12 and default `N_WORDS`=2 constants.
  - State enum `{HUNT, COLLECT}`.
  - A function that reverses the word order of a frame vector.
- One natural sub-module, `sat_counter` (`CNT_W`, `inc`, `clr`, `q`), instantiated twice.

Test Plan:
- Basic: `N_WORDS`=2, `decim`=0, `swap`=0; `sel`/`d` = (1,0x123),(0,0x456) -> next cycle `fifo_wr`=1, `fifo_data`=0x456123. Back-to-back frames give one `fifo_wr` every 2 cycles.
- Swap and 4-word: `N_WORDS`=4, `swap`=1, words 0x001,0x002,0x003,0x004 -> `fifo_data`=0x001002003004.
- Framing: `sel`=1 on the 2nd word of a 2-word frame -> `ferr_cnt`=1, no write, new frame starts on that word. Missing `sel` at frame start -> `ferr_cnt`++, `locked`=0 until the next `sel`.
- Full/drop: hold `fifo_full`=1 across 3 complete frames -> `fifo_wr` never asserts, `drop_cnt`=3, `fifo_data` unchanged. Then `clr_cnt` with a same-cycle drop -> `drop_cnt`=0.
- Decimation: `decim`=2, 9 complete frames -> exactly 3 writes, on frames 1, 4 and 7. `fifo_full`=1 on a skipped frame -> no drop counted.
- Reset and enable mid-frame:
  - `reset_n` low at word 1 -> all outputs 0 next cycle, partial frame discarded.
  - `enable` dropped mid-frame -> HUNT, no `ferr_cnt` change, no write.
